// File: rtl/decimal_to_gray.sv
// Registered binary<->Gray converter for decimal digits with a range flag.
// One-cycle latency; gray/err hold between accepted words, out_valid pulses per word.
module decimal_to_gray #(
    parameter int WIDTH   = 4,
    parameter int DEC_MAX = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             out_valid,
    output logic             err
);

    localparam logic [WIDTH-1:0] DEC_MAX_W = DEC_MAX[WIDTH-1:0];

    logic [WIDTH-1:0] enc;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] gray_next;
    logic             err_next;

    assign enc[WIDTH-1] = bin[WIDTH-1];
    assign dec[WIDTH-1] = bin[WIDTH-1];

    // Encode is a neighbour XOR; decode is a prefix-XOR ripple from the MSB.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign enc[gi] = bin[gi+1] ^ bin[gi];
            assign dec[gi] = dec[gi+1] ^ bin[gi];
        end
    endgenerate

    always_comb begin
        gray_next = mode ? dec : enc;
        // The range check always looks at the plain binary value of the digit.
        err_next  = mode ? (dec > DEC_MAX_W) : (bin > DEC_MAX_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray      <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                gray <= gray_next;
                err  <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_decimal_to_gray.sv
// Randomized and directed checks of decimal_to_gray against an arithmetic model.
module tb_decimal_to_gray;

    localparam int WIDTH   = 4;
    localparam int DEC_MAX = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] bin = '0;
    logic [WIDTH-1:0] gray;
    logic             out_valid;
    logic             err;

    int checks = 0;
    int passes = 0;

    decimal_to_gray #(.WIDTH(WIDTH), .DEC_MAX(DEC_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
        .bin(bin), .gray(gray), .out_valid(out_valid), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] to_gray(logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] from_gray(logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r = '0;
        for (int s = 0; s < WIDTH; s++) r ^= (g >> s);
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference outputs: what the registers must hold after each edge.
    logic [WIDTH-1:0] exp_gray;
    logic             exp_valid;
    logic             exp_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_gray  <= '0;
            exp_valid <= 1'b0;
            exp_err   <= 1'b0;
        end else begin
            exp_valid <= in_valid;
            if (in_valid) begin
                exp_gray <= mode ? from_gray(bin) : to_gray(bin);
                exp_err  <= (mode ? int'(from_gray(bin)) : int'(bin)) > DEC_MAX;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_gray", 32'(gray), 32'(exp_gray));
        chk("cyc_valid", 32'(out_valid), 32'(exp_valid));
        chk("cyc_err", 32'(err), 32'(exp_err));
    end

    // Apply one word, then return just after the edge that registered it.
    task automatic step(logic v, logic m, logic [WIDTH-1:0] b);
        in_valid = v;
        mode     = m;
        bin      = b;
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] sweep [10] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gray", 32'(gray), 0);
        chk("reset_valid", 32'(out_valid), 0);
        rst_n = 1'b1;

        step(1, 0, 4'd1);
        chk("first_gray", 32'(gray), 32'h1);
        chk("first_valid", 32'(out_valid), 1);
        chk("first_err", 32'(err), 0);
        step(0, 0, 4'd0);
        chk("first_drop", 32'(out_valid), 0);

        for (int i = 0; i < 10; i++) begin
            step(1, 0, 4'(i));
            chk("sweep_gray", 32'(gray), 32'(sweep[i]));
            chk("sweep_valid", 32'(out_valid), 1);
            chk("sweep_err", 32'(err), 0);
        end

        step(1, 0, 4'hA);
        chk("oor10_gray", 32'(gray), 32'hF);
        chk("oor10_err", 32'(err), 1);
        step(1, 0, 4'hF);
        chk("oor15_gray", 32'(gray), 32'h8);
        chk("oor15_err", 32'(err), 1);
        step(1, 0, 4'h3);
        chk("back_gray", 32'(gray), 32'h2);
        chk("back_err", 32'(err), 0);

        step(1, 1, 4'hD);
        chk("inv13_out", 32'(gray), 32'h9);
        chk("inv13_err", 32'(err), 0);
        step(1, 1, 4'hF);
        chk("inv15_out", 32'(gray), 32'hA);
        chk("inv15_err", 32'(err), 1);

        for (int i = 0; i < 40; i++) step(1, 1'(i), 4'($urandom_range(0, 15)));

        step(1, 0, 4'd5);
        chk("hold_pre", 32'(gray), 32'h7);
        for (int i = 0; i < 3; i++) begin
            step(0, 1'($urandom), 4'($urandom_range(0, 15)));
            chk("hold_gray", 32'(gray), 32'h7);
            chk("hold_err", 32'(err), 0);
            chk("hold_valid", 32'(out_valid), 0);
        end

        for (int i = 0; i < 300; i++)
            step(1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)));

        step(1, 0, 4'd9);
        chk("pre_rst_gray", 32'(gray), 32'hD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gray", 32'(gray), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_err", 32'(err), 0);
        step(1, 0, 4'hF);
        chk("rst_hold_gray", 32'(gray), 0);
        chk("rst_hold_valid", 32'(out_valid), 0);
        chk("rst_hold_err", 32'(err), 0);
        rst_n = 1'b1;
        step(1, 1, 4'h6);
        chk("post_rst_out", 32'(gray), 32'h4);
        chk("post_rst_valid", 32'(out_valid), 1);
        step(0, 0, 4'h0);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/decimal_to_gray.md
Name: decimal_to_gray

Overview:
Registered converter that maps a decimal digit, carried as an unsigned binary word, to its reflected-binary Gray code. It also offers the inverse Gray-to-binary conversion and flags inputs outside the legal decimal-digit range. It sits between digit-producing logic (counters, keypad/BCD decoders) and Gray-coded consumers such as displays and cross-domain pointers. All outputs are registered, with one-cycle latency.

Parameters:
WIDTH, 4, bit width of the input and output code words (minimum 2).
DEC_MAX, 9, largest legal decimal value; an input above this raises err (range 0 to 2^WIDTH-1).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input word qualifier; a conversion is sampled only when this is 1.
mode  input  1  0 = binary to Gray, 1 = Gray to binary.
bin  input  WIDTH  input word: binary digit in mode 0, Gray code in mode 1; bit WIDTH-1 is MSB.
gray  output  WIDTH  converted word: Gray code in mode 0, binary in mode 1; bit WIDTH-1 is MSB.
out_valid  output  1  1 for exactly one cycle per accepted input.
err  output  1  range error for the word currently on gray.

Behaviour:
- Reset: when rst_n=0, gray, out_valid and err clear to 0 immediately, without waiting for a clock edge. They stay 0 while rst_n is low.
- Reset release: the first rising clk edge after rst_n goes high samples inputs normally.
- Acceptance: on a rising clk edge with in_valid=1, the inputs are converted and registered.
  - The result appears on gray in the following cycle.
  - out_valid=1 for that one cycle.
- Idle: on an edge with in_valid=0, out_valid=0. gray and err hold their previous values.
- Back-to-back: in_valid held high accepts a new word every cycle. Throughput is 1 word per clock, and out_valid stays high continuously.
- Mode 0 (binary to Gray): gray[WIDTH-1] = bin[WIDTH-1]; gray[i] = bin[i+1] XOR bin[i] for i < WIDTH-1. Equivalently, gray = bin XOR (bin >> 1).
- Mode 1 (Gray to binary): out[WIDTH-1] = bin[WIDTH-1]; out[i] = out[i+1] XOR bin[i], computed from MSB down to LSB.
- Range check:
  - Mode 0: err = 1 when unsigned bin > DEC_MAX.
  - Mode 1: err = 1 when the decoded binary value > DEC_MAX.
  - err is registered alongside gray and updates only on accepted words.
  - The conversion is still performed and output when err = 1 (no saturation, no masking).
- Boundaries:
  - bin = 0 gives gray = 0.
  - bin = 2^WIDTH-1 converts to 1 followed by zeros (1000 for WIDTH=4).
  - No wrap-around state exists; the block is purely a registered function of its inputs.
- mode is sampled together with bin; changing mode between accepted words needs no idle cycle.
- Reset asserted mid-stream discards any pending result. No out_valid pulse is produced for a word sampled on the same edge on which reset is asserted.
- No X propagation: all registers have defined reset values.

Test Plan:
- Reset then decimal 1: rst_n=0, release, one cycle with in_valid=1, mode=0, bin=0001. The next cycle shows gray=0001, out_valid=1, err=0, and out_valid=0 one cycle after that.
- Full digit sweep, mode 0, bin=0..9 back-to-back: gray sequence is 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101. out_valid stays high for 10 consecutive cycles and err stays 0.
- Out-of-range, mode 0:
  - bin=1010 (10) gives gray=1111, err=1.
  - bin=1111 gives gray=1000, err=1.
  - A following bin=0011 gives gray=0010, err=0.
- Inverse conversion, mode 1:
  - bin=1101 gives gray=1001 (9), err=0.
  - bin=1111 gives gray=1010 (10), err=1.
  - Alternating mode every cycle gives correct per-word results.
- Hold: after an accepted word, drop in_valid for 3 cycles while toggling bin. gray and err are unchanged and out_valid=0.
- Asynchronous reset mid-stream: pull rst_n low between clock edges while gray=1101. gray, out_valid and err read 0 before the next clk edge, and remain 0 until rst_n returns high.
